// File: rtl/sd_bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector: buffers words in a small FIFO
// and shifts them out one bit per clock with no gap between back-to-back words.
module sd_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         ser_out,
  output logic                         ser_active,
  output logic                         word_done,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(WIDTH);
  localparam int unsigned FillW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FillW-1:0] fill_q, fill_d;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             ser_out_q, ser_out_d;
  logic             active_q, active_d;
  logic             done_q, done_d;

  logic             full, empty, push, pop;
  logic [WIDTH-1:0] head;
  logic             first_bit, next_bit;

  // Shift so that the next bit to send always sits at the output end of the register.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w << 1;
    end else begin
      return w >> 1;
    end
  endfunction

  assign full      = (fill_q == FillW'(DEPTH));
  assign empty     = (fill_q == '0);
  assign in_ready  = !full && !flush;
  assign push      = in_valid && in_ready;
  assign head      = mem_q[rd_ptr_q];
  assign first_bit = MSB_FIRST ? head[WIDTH-1] : head[0];
  assign next_bit  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

  // Shifter / output FSM
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    ser_out_d = IDLE_BIT;
    active_d  = 1'b0;
    done_d    = 1'b0;
    pop       = 1'b0;

    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            pop       = 1'b1;
            ser_out_d = first_bit;
            shreg_d   = shift_word(head);
            cnt_d     = CntW'(WIDTH - 1);
            active_d  = 1'b1;
            state_d   = StShift;
          end
        end
        StShift: begin
          if (cnt_q != '0) begin
            ser_out_d = next_bit;
            shreg_d   = shift_word(shreg_q);
            cnt_d     = cnt_q - CntW'(1);
            active_d  = 1'b1;
            done_d    = (cnt_q == CntW'(1));
          end else if (!empty) begin
            // Last bit is on the line: reload now so the next word follows without a gap.
            pop       = 1'b1;
            ser_out_d = first_bit;
            shreg_d   = shift_word(head);
            cnt_d     = CntW'(WIDTH - 1);
            active_d  = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FIFO bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        fill_d = fill_q + FillW'(1);
      end else if (pop && !push) begin
        fill_d = fill_q - FillW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      state_q   <= StIdle;
      cnt_q     <= '0;
      shreg_q   <= '0;
      ser_out_q <= IDLE_BIT;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      ser_out_q <= ser_out_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  assign ser_out    = ser_out_q;
  assign ser_active = active_q;
  assign word_done  = done_q;
  assign fill_level = fill_q;

endmodule

// File: tb/tb_sd_bit_serializer.sv
// Bench for sd_bit_serializer: MSB-first and LSB-first instances share stimulus and are
// checked every cycle against a word-queue / bit-index reference model.
module tb_sd_bit_serializer;

  localparam int W = 8;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset, flush, in_valid;
  logic [7:0] in_data;
  logic       m_ready, m_out, m_act, m_done;
  logic       l_ready, l_out, l_act, l_done;
  logic [2:0] m_fill, l_fill;

  sd_bit_serializer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .reset(reset), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(m_ready), .ser_out(m_out), .ser_active(m_act), .word_done(m_done),
    .fill_level(m_fill)
  );

  sd_bit_serializer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .reset(reset), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(l_ready), .ser_out(l_out), .ser_active(l_act), .word_done(l_done),
    .fill_level(l_fill)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: queue of buffered words, current word and index of the bit on the line.
  logic [7:0] mq[$];
  logic [7:0] cur;
  int         idx;
  logic       pre_ready;
  logic       acc;

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    idx = -1;
    cur = '0;
  endtask

  task automatic check_outputs();
    logic act, em, el, ed;
    act = (idx >= 0);
    em  = act ? cur[W-1-idx] : 1'b0;
    el  = act ? cur[idx] : 1'b0;
    ed  = (idx == W - 1);
    chk("m_ser_out", m_out, em);
    chk("m_ser_active", m_act, act);
    chk("m_word_done", m_done, ed);
    chk("m_fill_level", m_fill, mq.size());
    chk("l_ser_out", l_out, el);
    chk("l_ser_active", l_act, act);
    chk("l_word_done", l_done, ed);
    chk("l_fill_level", l_fill, mq.size());
  endtask

  // Called at posedge+1; drives inputs, checks in_ready, advances model, checks outputs.
  task automatic step(input logic v, input logic [7:0] d, input logic f);
    logic rdy;
    in_valid = v;
    in_data  = d;
    flush    = f;
    #1;
    rdy = (mq.size() < D) && !f;
    pre_ready = m_ready;
    chk("m_in_ready", m_ready, rdy);
    chk("l_in_ready", l_ready, rdy);
    acc = v && rdy;
    if (f) begin
      mq.delete();
      idx = -1;
    end else begin
      if (idx >= 0 && idx < W - 1) begin
        idx++;
      end else if (mq.size() > 0) begin
        cur = mq.pop_front();
        idx = 0;
      end else begin
        idx = -1;
      end
      if (acc) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       f;
    logic       eo;
    logic       ea;
    logic       ed;
    int         efill;
  } vec_t;

  vec_t       t1[11];
  logic [7:0] w1;
  logic       exp3[8];
  int         act_cnt, done_cnt, first_act, last_act, prev_done, wi;

  initial begin
    // Test 1 table: push 8'h06, expect 0,0,0,0,0,1,1,0 then idle.
    w1 = 8'h06;
    t1[0] = '{1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    for (int i = 1; i <= 8; i++) t1[i] = '{1'b0, 8'h00, 1'b0, w1[8-i], 1'b1, (i == 8), 0};
    t1[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    t1[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    exp3 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    model_reset();
    #1;
    chk("rst_ser_out", m_out, 0);
    chk("rst_ser_active", m_act, 0);
    chk("rst_word_done", m_done, 0);
    chk("rst_fill", m_fill, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("ready_after_reset", m_ready, 1);
    @(posedge clk);
    #1;

    // Test 1
    for (int i = 0; i < 11; i++) begin
      step(t1[i].v, t1[i].d, t1[i].f);
      chk($sformatf("t1_out[%0d]", i), m_out, t1[i].eo);
      chk($sformatf("t1_act[%0d]", i), m_act, t1[i].ea);
      chk($sformatf("t1_done[%0d]", i), m_done, t1[i].ed);
      chk($sformatf("t1_fill[%0d]", i), m_fill, t1[i].efill);
    end

    // Test 2: in_valid held with 6 words from edge 0.
    wi = 0; act_cnt = 0; done_cnt = 0; first_act = -1; last_act = -1; prev_done = -1;
    for (int e = 0; e < 60; e++) begin
      step(wi < 6, 8'h11 * (wi + 1) + 8'h01, 1'b0);
      if (e == 9) chk("t2_push_blocked_e9", acc, 0);
      if (e == 10) chk("t2_push_accepted_e10", acc, 1);
      if (acc) wi++;
      if (e == 4) chk("t2_fill_full", m_fill, 4);
      if (e == 5) chk("t2_ready_low_e5", pre_ready, 0);
      if (m_act) begin
        act_cnt++;
        if (first_act < 0) first_act = e;
        last_act = e;
      end
      if (m_done) begin
        done_cnt++;
        if (prev_done >= 0) chk("t2_done_spacing", e - prev_done, 8);
        prev_done = e;
      end
    end
    chk("t2_active_cycles", act_cnt, 48);
    chk("t2_done_pulses", done_cnt, 6);
    chk("t2_first_active", first_act, 1);
    chk("t2_last_active", last_act, 48);

    // Test 3: LSB-first instance.
    step(1'b1, 8'b1000_0011, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b0);
      chk($sformatf("t3_lsb_bit[%0d]", i), l_out, exp3[i]);
    end
    idle(2);

    // Test 4: flush during 4th bit with 2 words queued.
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'h3C, 1'b0);
    step(1'b1, 8'hE7, 1'b0);
    idle(2);
    chk("t4_fill_before", m_fill, 2);
    step(1'b1, 8'h5A, 1'b1);
    chk("t4_ready_during_flush", pre_ready, 0);
    chk("t4_ser_out", m_out, 0);
    chk("t4_active", m_act, 0);
    chk("t4_fill", m_fill, 0);
    step(1'b0, 8'h00, 1'b0);
    chk("t4_no_push", m_fill, 0);
    chk("t4_still_idle", m_act, 0);
    idle(2);

    // Test 5: asynchronous reset mid-word.
    step(1'b1, 8'hC3, 1'b0);
    idle(3);
    in_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("t5_async_ser_out", m_out, 0);
    chk("t5_async_active", m_act, 0);
    chk("t5_async_done", m_done, 0);
    chk("t5_async_fill", m_fill, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1, 8'hFF, 1'b0);
    chk("t5_not_yet", m_act, 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b0);
      chk($sformatf("t5_one[%0d]", i), m_out, 1);
    end
    idle(2);

    // Test 6: push at fill 3 on a pop edge.
    step(1'b1, 8'h81, 1'b0);
    step(1'b1, 8'h42, 1'b0);
    step(1'b1, 8'h24, 1'b0);
    step(1'b1, 8'h18, 1'b0);
    idle(5);
    chk("t6_fill_pre", m_fill, 3);
    step(1'b1, 8'hF0, 1'b0);
    chk("t6_accepted", acc, 1);
    chk("t6_fill_post", m_fill, 3);
    idle(40);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 49) == 0);
    end
    idle(45);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_bit_serializer.md
Name: sd_bit_serializer

Overview:
- Upstream feeder for the serial sequence-detector stage.
- Accepts parallel words over a valid/ready handshake and buffers them in a small FIFO.
- Emits one bit per clock on a registered serial output that drives the detector's data input directly.
- Streams back-to-back words with no gap cycles; drives a fixed idle level when it has no data.

Parameters:
WIDTH, 8, bits per parallel word (>=2)
DEPTH, 4, FIFO entries (power of two, >=2)
MSB_FIRST, 1, 1 = bit WIDTH-1 shifted out first, 0 = bit 0 first
IDLE_BIT, 0, value driven on ser_out when no word is being shifted

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
flush  input  1  synchronous clear of FIFO and shifter
in_data  input  WIDTH  parallel word
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a word this cycle
ser_out  output  1  serial bit stream to detector din (registered)
ser_active  output  1  ser_out carries a data bit this cycle (registered)
word_done  output  1  ser_out carries the last bit of a word this cycle (registered)
fill_level  output  $clog2(DEPTH+1)  words currently held in FIFO (excludes the word in the shifter)

Behaviour:
- Reset (async, active-high): FIFO empty, fill_level=0, state IDLE, ser_out=IDLE_BIT, ser_active=0, word_done=0. in_ready=1 once reset is released.
- in_ready is combinational: in_ready = !full && !flush.
  - A push occurs on an edge where in_valid && in_ready.
  - A push is blocked when the FIFO is full, even if a pop happens on the same edge; no bypass when full.
- Push and pop on the same edge (FIFO not full): both take effect and fill_level is unchanged.
- Pointers wrap modulo DEPTH. fill_level ranges 0..DEPTH.
- States:
  - IDLE: no word in shifter.
  - SHIFT: word in shifter, bit counter cnt = bits remaining after the current ser_out bit.
- IDLE, FIFO non-empty:
  - On that edge: pop the head word; ser_out <= its first bit (per MSB_FIRST); load the remaining WIDTH-1 bits into the shifter; cnt <= WIDTH-1; ser_active <= 1; state -> SHIFT.
  - A word pushed into an empty FIFO at edge N has its first bit on ser_out after edge N+1.
- IDLE, FIFO empty: ser_out <= IDLE_BIT, ser_active <= 0.
- SHIFT, cnt>0: ser_out <= next bit; cnt <= cnt-1; ser_active stays 1.
- SHIFT, cnt==0 (current ser_out is the last bit):
  - If the FIFO is non-empty: pop and load as in IDLE on the same edge, so streaming is contiguous.
  - Otherwise: ser_out <= IDLE_BIT, ser_active <= 0, state -> IDLE.
- word_done <= 1 on the edge that places a word's last bit on ser_out, 0 otherwise. Each word produces exactly one word_done pulse.
- Each word occupies exactly WIDTH consecutive ser_active cycles.
- flush (synchronous, highest priority after reset):
  - On the flush edge: FIFO emptied, shifter discarded, state -> IDLE, ser_out <= IDLE_BIT, ser_active <= 0, word_done <= 0.
  - in_ready=0 while flush is high, so a push presented in that cycle is not accepted.
- Reset mid-word: the partial word and all buffered words are lost; outputs return to reset values immediately (asynchronously).
- in_data is sampled only on an accepted push. It is don't-care otherwise.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, IDLE_BIT=0: push 8'h06 at edge N.
   - ser_out after edges N+1..N+8 = 0,0,0,0,0,1,1,0.
   - ser_active=1 for exactly those 8 cycles.
   - word_done=1 only after edge N+8.
   - ser_out=0 and ser_active=0 from edge N+9.
2. in_valid held high with 6 words pushed from edge 0.
   - fill_level reaches 4 after edge 4 and in_ready drops.
   - The 6th word is accepted only after the pop at edge 9 frees a slot.
   - 48 contiguous ser_active cycles, 6 word_done pulses spaced 8 cycles apart.
3. MSB_FIRST=0: push 8'b1000_0011 -> ser_out sequence 1,1,0,0,0,0,0,1.
4. flush asserted during the 4th bit of a word, with 2 words queued.
   - Next cycle: ser_out=IDLE_BIT, ser_active=0, fill_level=0, in_ready=0 during flush.
   - A push presented in the same cycle is not accepted.
5. reset asserted asynchronously mid-word.
   - Outputs go to reset values without waiting for a clock edge.
   - After release, a new push of 8'hFF streams 8 ones starting 2 edges later.
6. Push while fill_level=3 and a pop occurs on the same edge -> fill_level stays 3 and word order is preserved.
